ahbl_master_stage: RTL and testbench
====================================

# ahbl_master_stage

Per-master front end of the AHB-Lite bus matrix, one instance per master port, sitting directly upstream of each slave stage. It decodes the master's address into one of 16 slave regions and presents a gated address phase to the selected slave stage. When that slave stage does not grant, it holds the address and stalls the master. It tracks the outstanding data phase, muxes read data and response back to the master, and generates the two-cycle ERROR response for unmapped regions.

## Interface
Parameters:
- SLAVE_EN, 16'hFFFF, bit s=1 maps region HADDR[31:28]==s to slave s; 0 = unmapped (ERROR)

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- HADDR  in  32  master address
- HTRANS  in  2  master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- HBURST  in  3  master burst type
- HSIZE  in  3  master size
- HWRITE  in  1  master direction
- HMASTLOCK  in  1  master lock
- HREADY_M  out  1  ready to master
- HRESP_M  out  1  response to master
- HRDATA_M  out  32  read data to master
- ADDRSEL  out  16  one-hot address-phase request per slave stage
- DATASEL  out  16  one-hot data-phase owner per slave stage
- PREVDATASLAVEREADY  out  1  copy of HREADY_M, consumed by the slave stages
- GATEDHADDR / GATEDHTRANS / GATEDHBURST / GATEDHSIZE / GATEDHWRITE / GATEDHMASTLOCK  out  32/2/3/3/1/1  address phase to the slave stages
- GATEDBURSTXFER  out  1  address phase belongs to a burst
- SADDRREADY  in  16  per-slave address grant/ready
- SDATAREADY  in  16  per-slave data-phase ready
- SHRESP  in  16  per-slave response
- HRDATA_S  in  512  slave read data; slave s occupies bits [32s+31:32s]

## Operation
- States: IDLE (no data phase outstanding), DATA (data phase owned by slave d), HOLD (address latched, awaiting grant), ERR1, ERR2.
- An address is **active** when HTRANS is NONSEQ or SEQ. BUSY and IDLE are never forwarded.
- The region index is s = HADDR[31:28].
- HREADY_M per state:
  - IDLE: 1
  - DATA: SDATAREADY[d]
  - HOLD: 0
  - ERR1: 0
  - ERR2: 1
- Accept cycle is HREADY_M=1. In an accept cycle:
  - Active address, SLAVE_EN[s]=1, SADDRREADY[s]=1: ADDRSEL[s]=1, gated outputs driven live, next state DATA with d=s.
  - Active address, SLAVE_EN[s]=1, SADDRREADY[s]=0: ADDRSEL[s]=1, capture the address/control into the hold register, next state HOLD with h=s.
  - Active address, SLAVE_EN[s]=0: ADDRSEL=0, next state ERR1.
  - Non-active address: ADDRSEL=0, GATEDHTRANS=IDLE, next state IDLE.
- HOLD:
  - ADDRSEL[h]=1; gated outputs come from the hold register; master inputs are ignored.
  - SADDRREADY[h]=1 → DATA with d=h.
- Error sequence: ERR1 drives HRESP_M=1 → ERR2 drives HRESP_M=1 and is an accept cycle (decoded as above).
- DATASEL is one-hot d in DATA, 0 otherwise.
- HRESP_M = SHRESP[d] in DATA. HRDATA_M = HRDATA_S[d] in DATA, 0 otherwise.
- GATEDBURSTXFER = (GATEDHTRANS==SEQ) | (GATEDHTRANS==NONSEQ & GATEDHBURST!=0).
- When ADDRSEL=0, all gated outputs are 0.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, hold register=0, d=0.
  - HREADY_M=1, HRESP_M=0, HRDATA_M=0, ADDRSEL=0, DATASEL=0, all gated outputs 0.
- Latency:
  - Granted address reaches the slave stage in the same cycle (0 added).
  - Each ungranted cycle adds 1 stall cycle.
  - Unmapped access takes exactly 2 data-phase cycles.
- Slave two-cycle ERROR (SDATAREADY=0 & SHRESP=1, then 1/1) passes through unchanged.
- Reset asserted mid-HOLD or mid-ERR: the held address is discarded and no ADDRSEL is asserted afterwards.
- DATA with SDATAREADY[d]=1 and a new address to a busy slave: the data phase completes and the next state is HOLD, in the same edge.

## Structure
- Package ahbl_pkg holds:
  - state enum
  - HTRANS/HBURST encodings
  - NSLV=16
  - region field position [31:28]
- Sub-module ahbl_addr_decode: combinational HADDR + SLAVE_EN → one-hot region, unmapped flag.

## Test plan
- Reset values: assert HRESET asynchronously in DATA → all outputs go to reset values within the same cycle; state is IDLE.
- Granted single write: NONSEQ to 0x3000_0010 with SADDRREADY[3]=1 → ADDRSEL=16'h0008 and GATEDHADDR=0x3000_0010 that cycle; next cycle DATASEL=16'h0008, HREADY_M follows SDATAREADY[3].
- Hold: NONSEQ to 0x5000_0000 with SADDRREADY[5]=0 for 3 cycles while HADDR changes to garbage →
  - HREADY_M=0 for 3 cycles
  - GATEDHADDR stays 0x5000_0000
  - DATA entered when grant arrives
- Unmapped: SLAVE_EN=16'h00FF, NONSEQ to 0xA000_0000 → ERR1 (HREADY_M=0, HRESP_M=1), then ERR2 (HREADY_M=1, HRESP_M=1), then IDLE.
- Pipelined INCR4 read to slave 1 → GATEDBURSTXFER=1 on all 4 beats; HRDATA_M equals HRDATA_S[63:32] for each beat; BUSY beat gives GATEDHTRANS=IDLE and ADDRSEL=0.
- Slave error: SHRESP[2]=1 with SDATAREADY[2]=0 then 1 → HRESP_M=1 for both cycles, HREADY_M=0 then 1.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared types and constants for the AHB-Lite master stage.
package ahbl_pkg;

    localparam int unsigned NSLV      = 16;
    localparam int unsigned RegionMsb = 31;
    localparam int unsigned RegionLsb = 28;

    typedef enum logic [1:0] {
        TransIdle   = 2'd0,
        TransBusy   = 2'd1,
        TransNonseq = 2'd2,
        TransSeq    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        BurstSingle = 3'd0,
        BurstIncr   = 3'd1,
        BurstWrap4  = 3'd2,
        BurstIncr4  = 3'd3,
        BurstWrap8  = 3'd4,
        BurstIncr8  = 3'd5,
        BurstWrap16 = 3'd6,
        BurstIncr16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StHold,
        StErr1,
        StErr2
    } state_e;

    // One complete address phase as forwarded to a slave stage
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [2:0]  size;
        logic        write;
        logic        lock;
    } addr_phase_t;

    function automatic logic is_active(input logic [1:0] trans);
        return (trans == TransNonseq) || (trans == TransSeq);
    endfunction

    function automatic logic is_burst_xfer(input logic [1:0] trans, input logic [2:0] burst);
        return (trans == TransSeq) || ((trans == TransNonseq) && (burst != BurstSingle));
    endfunction

endpackage

// File: rtl/ahbl_master_stage_if.sv
// Bus bundle between one AHB-Lite master port and its master stage.
interface ahbl_master_stage_if;
    import ahbl_pkg::*;

    // master side
    logic [31:0]        HADDR;
    logic [1:0]         HTRANS;
    logic [2:0]         HBURST;
    logic [2:0]         HSIZE;
    logic               HWRITE;
    logic               HMASTLOCK;
    logic               HREADY_M;
    logic               HRESP_M;
    logic [31:0]        HRDATA_M;
    // slave-stage side
    logic [NSLV-1:0]    ADDRSEL;
    logic [NSLV-1:0]    DATASEL;
    logic               PREVDATASLAVEREADY;
    logic [31:0]        GATEDHADDR;
    logic [1:0]         GATEDHTRANS;
    logic [2:0]         GATEDHBURST;
    logic [2:0]         GATEDHSIZE;
    logic               GATEDHWRITE;
    logic               GATEDHMASTLOCK;
    logic               GATEDBURSTXFER;
    logic [NSLV-1:0]    SADDRREADY;
    logic [NSLV-1:0]    SDATAREADY;
    logic [NSLV-1:0]    SHRESP;
    logic [32*NSLV-1:0] HRDATA_S;

    // The stage itself
    modport slave (
        input  HADDR, HTRANS, HBURST, HSIZE, HWRITE, HMASTLOCK,
        input  SADDRREADY, SDATAREADY, SHRESP, HRDATA_S,
        output HREADY_M, HRESP_M, HRDATA_M, ADDRSEL, DATASEL, PREVDATASLAVEREADY,
        output GATEDHADDR, GATEDHTRANS, GATEDHBURST, GATEDHSIZE, GATEDHWRITE,
        output GATEDHMASTLOCK, GATEDBURSTXFER
    );

    // Whatever drives the master port and models the slave stages
    modport master (
        output HADDR, HTRANS, HBURST, HSIZE, HWRITE, HMASTLOCK,
        output SADDRREADY, SDATAREADY, SHRESP, HRDATA_S,
        input  HREADY_M, HRESP_M, HRDATA_M, ADDRSEL, DATASEL, PREVDATASLAVEREADY,
        input  GATEDHADDR, GATEDHTRANS, GATEDHBURST, GATEDHSIZE, GATEDHWRITE,
        input  GATEDHMASTLOCK, GATEDBURSTXFER
    );

endinterface

// File: rtl/ahbl_addr_decode.sv
// Region decoder: top address nibble selects one of NSLV slave regions.
module ahbl_addr_decode
    import ahbl_pkg::*;
(
    input  logic [31:0]     haddr_i,
    input  logic [NSLV-1:0] slave_en_i,
    output logic [3:0]      region_o,
    output logic [NSLV-1:0] region_oh_o,
    output logic            unmapped_o
);

    logic unused_low_addr;
    assign unused_low_addr = ^haddr_i[RegionLsb-1:0];

    // One-hot is zero for an unmapped region so it can drive ADDRSEL directly
    always_comb begin
        region_o              = haddr_i[RegionMsb:RegionLsb];
        region_oh_o           = '0;
        region_oh_o[region_o] = slave_en_i[region_o];
        unmapped_o            = ~slave_en_i[region_o];
    end

endmodule

// File: rtl/ahbl_master_stage.sv
// Per-master front end: decode, hold on no-grant, data-phase tracking, ERROR generation.
module ahbl_master_stage
    import ahbl_pkg::*;
#(
    parameter logic [NSLV-1:0] SLAVE_EN = 16'hFFFF
) (
    input logic                HCLK,
    input logic                HRESET,
    ahbl_master_stage_if.slave bus
);

    state_e      state_q, state_d;
    logic [3:0]  dslv_q, dslv_d;
    addr_phase_t hold_q, hold_d;

    logic [3:0]      region;
    logic [NSLV-1:0] region_oh;
    logic            unmapped;
    logic            accept;
    logic            active;
    logic [3:0]      hold_region;
    logic [NSLV-1:0] addrsel;
    addr_phase_t     live;
    addr_phase_t     gated;

    ahbl_addr_decode u_decode (
        .haddr_i     (bus.HADDR),
        .slave_en_i  (SLAVE_EN),
        .region_o    (region),
        .region_oh_o (region_oh),
        .unmapped_o  (unmapped)
    );

    // Master-facing ready/response/read-data and data-phase owner
    always_comb begin
        bus.HREADY_M = 1'b1;
        bus.HRESP_M  = 1'b0;
        bus.HRDATA_M = '0;
        bus.DATASEL  = '0;
        unique case (state_q)
            StData: begin
                bus.HREADY_M        = bus.SDATAREADY[dslv_q];
                bus.HRESP_M         = bus.SHRESP[dslv_q];
                bus.HRDATA_M        = bus.HRDATA_S[{dslv_q, 5'd0} +: 32];
                bus.DATASEL[dslv_q] = 1'b1;
            end
            StHold: bus.HREADY_M = 1'b0;
            StErr1: begin
                bus.HREADY_M = 1'b0;
                bus.HRESP_M  = 1'b1;
            end
            StErr2: bus.HRESP_M = 1'b1;
            default: ;
        endcase
    end

    // Address-phase source: hold register while stalled, else the live master inputs
    always_comb begin
        live        = '{addr:  bus.HADDR,  trans: bus.HTRANS,  burst: bus.HBURST,
                        size:  bus.HSIZE,  write: bus.HWRITE,  lock:  bus.HMASTLOCK};
        active      = is_active(bus.HTRANS);
        // Gate with reset so nothing is requested while reset is held
        accept      = bus.HREADY_M & ~HRESET;
        hold_region = hold_q.addr[RegionMsb:RegionLsb];
        addrsel     = '0;
        gated       = '0;
        if (state_q == StHold) begin
            addrsel[hold_region] = 1'b1;
            gated                = hold_q;
        end else if (accept && active && !unmapped) begin
            addrsel = region_oh;
            gated   = live;
        end
    end

    assign bus.ADDRSEL            = addrsel;
    assign bus.GATEDHADDR         = gated.addr;
    assign bus.GATEDHTRANS        = gated.trans;
    assign bus.GATEDHBURST        = gated.burst;
    assign bus.GATEDHSIZE         = gated.size;
    assign bus.GATEDHWRITE        = gated.write;
    assign bus.GATEDHMASTLOCK     = gated.lock;
    assign bus.GATEDBURSTXFER     = is_burst_xfer(gated.trans, gated.burst);
    assign bus.PREVDATASLAVEREADY = bus.HREADY_M;

    // Next state: HOLD waits for grant, ERR1 always moves on, accept cycles decode
    always_comb begin
        state_d = state_q;
        dslv_d  = dslv_q;
        hold_d  = hold_q;
        if (state_q == StHold) begin
            if (bus.SADDRREADY[hold_region]) begin
                state_d = StData;
                dslv_d  = hold_region;
            end
        end else if (state_q == StErr1) begin
            state_d = StErr2;
        end else if (accept) begin
            if (!active) begin
                state_d = StIdle;
            end else if (unmapped) begin
                state_d = StErr1;
            end else if (bus.SADDRREADY[region]) begin
                state_d = StData;
                dslv_d  = region;
            end else begin
                state_d = StHold;
                hold_d  = live;
            end
        end
    end

    // State registers
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StIdle;
            dslv_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            dslv_q  <= dslv_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_ahbl_master_stage.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_ahbl_master_stage;

    localparam logic [15:0] SlaveEn = 16'hF0FF;

    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    ahbl_master_stage_if bus ();

    ahbl_master_stage #(.SLAVE_EN(SlaveEn)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model: who owns the data phase, whether an address is parked, error countdown
    int          owner;
    bit          held;
    logic [31:0] h_addr;
    logic [1:0]  h_trans;
    logic [2:0]  h_burst, h_size;
    logic        h_write, h_lock;
    int          err_left;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_act(input logic [1:0] t);
        return (t == 2'd2) || (t == 2'd3);
    endfunction

    task automatic model_reset();
        owner    = -1;
        held     = 1'b0;
        err_left = 0;
        h_addr   = '0;
        h_trans  = '0;
        h_burst  = '0;
        h_size   = '0;
        h_write  = 1'b0;
        h_lock   = 1'b0;
    endtask

    function automatic bit model_ready();
        if (HRESET) return 1'b1;
        if (err_left == 2) return 1'b0;
        if (err_left == 1) return 1'b1;
        if (held) return 1'b0;
        if (owner >= 0) return bus.SDATAREADY[owner];
        return 1'b1;
    endfunction

    task automatic check_outputs();
        logic        e_rdy, e_resp, e_wr, e_lock, e_bx;
        logic [31:0] e_rdata, e_addr;
        logic [15:0] e_asel, e_dsel;
        logic [1:0]  e_trans;
        logic [2:0]  e_burst, e_size;
        int          s;
        bit          sel;
        e_rdy = model_ready();
        e_resp = 1'b0; e_rdata = '0; e_dsel = '0; e_asel = '0;
        e_addr = '0; e_trans = '0; e_burst = '0; e_size = '0; e_wr = 1'b0; e_lock = 1'b0;
        sel = 1'b0;
        s = 0;
        if (!HRESET) begin
            if (err_left != 0) begin
                e_resp = 1'b1;
            end else if (!held && owner >= 0) begin
                e_resp  = bus.SHRESP[owner];
                e_rdata = bus.HRDATA_S[owner*32 +: 32];
                e_dsel  = 16'(1) << owner;
            end
            if (held) begin
                sel = 1'b1; s = int'(h_addr[31:28]);
                e_addr = h_addr; e_trans = h_trans; e_burst = h_burst;
                e_size = h_size; e_wr = h_write; e_lock = h_lock;
            end else if (e_rdy && is_act(bus.HTRANS) && SlaveEn[bus.HADDR[31:28]]) begin
                sel = 1'b1; s = int'(bus.HADDR[31:28]);
                e_addr = bus.HADDR; e_trans = bus.HTRANS; e_burst = bus.HBURST;
                e_size = bus.HSIZE; e_wr = bus.HWRITE; e_lock = bus.HMASTLOCK;
            end
            if (sel) e_asel = 16'(1) << s;
        end
        e_bx = (e_trans == 2'd3) || (e_trans == 2'd2 && e_burst != 3'd0);
        chk("hready",   64'(bus.HREADY_M),           64'(e_rdy));
        chk("prevrdy",  64'(bus.PREVDATASLAVEREADY), 64'(e_rdy));
        chk("hresp",    64'(bus.HRESP_M),            64'(e_resp));
        chk("hrdata",   64'(bus.HRDATA_M),           64'(e_rdata));
        chk("addrsel",  64'(bus.ADDRSEL),            64'(e_asel));
        chk("datasel",  64'(bus.DATASEL),            64'(e_dsel));
        chk("g_addr",   64'(bus.GATEDHADDR),         64'(e_addr));
        chk("g_trans",  64'(bus.GATEDHTRANS),        64'(e_trans));
        chk("g_burst",  64'(bus.GATEDHBURST),        64'(e_burst));
        chk("g_size",   64'(bus.GATEDHSIZE),         64'(e_size));
        chk("g_write",  64'(bus.GATEDHWRITE),        64'(e_wr));
        chk("g_lock",   64'(bus.GATEDHMASTLOCK),     64'(e_lock));
        chk("g_bxfer",  64'(bus.GATEDBURSTXFER),     64'(e_bx));
    endtask

    task automatic model_update();
        int s;
        if (HRESET) begin
            model_reset();
            return;
        end
        s = int'(bus.HADDR[31:28]);
        if (held) begin
            if (bus.SADDRREADY[h_addr[31:28]]) begin
                owner = int'(h_addr[31:28]);
                held  = 1'b0;
            end
        end else if (err_left == 2) begin
            err_left = 1;
        end else if (model_ready()) begin
            owner    = -1;
            err_left = 0;
            if (is_act(bus.HTRANS)) begin
                if (!SlaveEn[s]) begin
                    err_left = 2;
                end else if (bus.SADDRREADY[s]) begin
                    owner = s;
                end else begin
                    held = 1'b1;
                    h_addr = bus.HADDR; h_trans = bus.HTRANS; h_burst = bus.HBURST;
                    h_size = bus.HSIZE; h_write = bus.HWRITE; h_lock = bus.HMASTLOCK;
                end
            end
        end
    endtask

    // Called at posedge+1 with inputs already set; checks mid-cycle, advances one clock
    task automatic step();
        #4;
        check_outputs();
        @(posedge HCLK);
        model_update();
        #1;
    endtask

    // Assert reset between edges and check outputs respond immediately
    task automatic async_reset();
        #1;
        HRESET = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge HCLK);
        model_update();
        #1;
        HRESET = 1'b0;
    endtask

    task automatic set_idle();
        bus.HTRANS = 2'd0; bus.HADDR = '0; bus.HBURST = 3'd0; bus.HSIZE = 3'd2;
        bus.HWRITE = 1'b0; bus.HMASTLOCK = 1'b0;
        bus.SADDRREADY = '1; bus.SDATAREADY = '1; bus.SHRESP = '0;
        for (int i = 0; i < 16; i++) bus.HRDATA_S[i*32 +: 32] = $urandom;
    endtask

    task automatic nonseq(input logic [31:0] a, input logic wr);
        bus.HTRANS = 2'd2; bus.HADDR = a; bus.HWRITE = wr; bus.HBURST = 3'd0;
    endtask

    task automatic rand_inputs();
        bus.HTRANS    = 2'($urandom_range(0, 3));
        bus.HADDR     = {4'($urandom_range(0, 15)), 28'($urandom)};
        bus.HBURST    = 3'($urandom_range(0, 7));
        bus.HSIZE     = 3'($urandom_range(0, 2));
        bus.HWRITE    = 1'($urandom_range(0, 1));
        bus.HMASTLOCK = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < 16; i++) begin
            bus.SADDRREADY[i]        = ($urandom_range(0, 9) < 6);
            bus.SDATAREADY[i]        = ($urandom_range(0, 9) < 7);
            bus.SHRESP[i]            = ($urandom_range(0, 9) == 0);
            bus.HRDATA_S[i*32 +: 32] = $urandom;
        end
    endtask

    initial begin
        logic [1:0] beats [5];
        beats = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd3};
        model_reset();
        HRESET = 1'b1;
        set_idle();
        nonseq(32'h3000_0000, 1'b1);  // active request during reset must not leak out
        @(posedge HCLK);
        #1;
        step();
        HRESET = 1'b0;
        set_idle();
        step();

        // Granted single write, then data phase stalled by the slave
        nonseq(32'h3000_0010, 1'b1);
        step();
        set_idle();
        bus.SDATAREADY[3] = 1'b0;
        step();
        bus.SDATAREADY[3] = 1'b1;
        step();

        // Asynchronous reset while in DATA
        nonseq(32'h3000_0020, 1'b0);
        step();
        bus.SDATAREADY[3] = 1'b0;
        nonseq(32'h4000_0000, 1'b0);
        async_reset();
        set_idle();
        step();

        // Hold with garbage on HADDR until the grant arrives
        nonseq(32'h5000_0000, 1'b0);
        bus.SADDRREADY[5] = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            bus.HADDR = $urandom;
            bus.HTRANS = 2'($urandom_range(0, 3));
            step();
        end
        bus.SADDRREADY[5] = 1'b1;
        step();
        set_idle();
        step();

        // Unmapped region: two-cycle ERROR
        nonseq(32'hA000_0000, 1'b0);
        step();
        set_idle();
        repeat (3) step();

        // Pipelined INCR4 read to slave 1 with a BUSY beat
        for (int i = 0; i < 5; i++) begin
            bus.HTRANS = beats[i];
            bus.HADDR  = 32'h1000_0000 + 32'(4 * i);
            bus.HBURST = 3'd3;
            bus.HWRITE = 1'b0;
            for (int k = 0; k < 16; k++) bus.HRDATA_S[k*32 +: 32] = $urandom;
            step();
        end
        set_idle();
        step();

        // Slave two-cycle ERROR passes through
        nonseq(32'h2000_0000, 1'b0);
        step();
        set_idle();
        bus.SDATAREADY[2] = 1'b0;
        bus.SHRESP[2]     = 1'b1;
        step();
        bus.SDATAREADY[2] = 1'b1;
        step();
        set_idle();
        step();

        // Data phase completes while the next address goes straight to HOLD
        nonseq(32'h4000_0000, 1'b1);
        step();
        nonseq(32'h7000_0100, 1'b0);
        bus.SADDRREADY[7] = 1'b0;
        step();
        step();
        bus.SADDRREADY[7] = 1'b1;
        step();
        set_idle();
        step();

        // Reset mid-HOLD and mid-ERR discards the pending work
        nonseq(32'h6000_0000, 1'b0);
        bus.SADDRREADY[6] = 1'b0;
        step();
        async_reset();
        set_idle();
        repeat (2) step();
        nonseq(32'hB000_0000, 1'b0);
        step();
        set_idle();
        async_reset();
        repeat (2) step();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            rand_inputs();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
